// File: rtl/prbs_checker_16.sv
// Receive-side checker for the x^16+x^14+x^13+x^11+1 PRBS word stream.
// It locks onto the stream, then runs its own prediction and counts mismatching words.
module prbs_checker_16 #(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_valid,
    input  logic [15:0]      data_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt
);
    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             have_ref_q, have_ref_d;
    logic [15:0]      ref_q, ref_d;
    logic [15:0]      exp_q, exp_d;
    logic [3:0]       match_run_q, match_run_d;
    logic [3:0]       miss_run_q, miss_run_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    function automatic logic [15:0] nxt(input logic [15:0] w);
        return {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
    endfunction

    always_comb begin
        state_d     = state_q;
        have_ref_d  = have_ref_q;
        ref_d       = ref_q;
        exp_d       = exp_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;

        if (data_valid) begin
            case (state_q)
                SEARCH: begin
                    // An all-zero word cannot come from the generator, so it is skipped.
                    if (data_in != 16'h0000) begin
                        if (have_ref_q && (data_in == nxt(ref_q))) begin
                            match_run_d = match_run_q + 4'd1;
                            if (match_run_d == 4'(LOCK_CNT)) begin
                                state_d    = LOCKED;
                                exp_d      = nxt(data_in);
                                miss_run_d = 4'd0;
                            end
                        end else begin
                            match_run_d = 4'd0;
                        end
                        ref_d      = data_in;
                        have_ref_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (word_cnt_q != '1)
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    exp_d = nxt(exp_q);
                    if (data_in == exp_q) begin
                        miss_run_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1)
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        miss_run_d = miss_run_q + 4'd1;
                        if (miss_run_d == 4'(UNLOCK_CNT)) begin
                            state_d     = SEARCH;
                            have_ref_d  = 1'b0;
                            match_run_d = 4'd0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (clr_cnt) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            have_ref_q  <= 1'b0;
            ref_q       <= 16'h0000;
            exp_q       <= 16'h0000;
            match_run_q <= 4'd0;
            miss_run_q  <= 4'd0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            have_ref_q  <= have_ref_d;
            ref_q       <= ref_d;
            exp_q       <= exp_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_prbs_checker_16.sv
// Directed bench for prbs_checker_16; a second narrow-counter instance covers saturation.
module tb_prbs_checker_16;
    logic        clk = 1'b0;
    logic        reset;
    logic        data_valid;
    logic [15:0] data_in;
    logic        clr_cnt;
    logic        locked, err_pulse;
    logic [15:0] err_cnt, word_cnt;
    logic        locked_s, err_pulse_s;
    logic [1:0]  err_cnt_s, word_cnt_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prbs_checker_16 #(.LOCK_CNT(3), .UNLOCK_CNT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
        .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    // Narrow counters and a long unlock run so five straight errors stay locked.
    prbs_checker_16 #(.LOCK_CNT(3), .UNLOCK_CNT(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
        .clr_cnt(clr_cnt), .locked(locked_s), .err_pulse(err_pulse_s),
        .err_cnt(err_cnt_s), .word_cnt(word_cnt_s)
    );

    task automatic step(input logic v, input logic [15:0] d, input logic c);
        data_valid = v;
        data_in    = d;
        clr_cnt    = c;
        @(posedge clk);
        #1;
        $display("txn valid=%0b data=%04h clr=%0b -> locked=%0b err_pulse=%0b err_cnt=%0d word_cnt=%0d",
                 v, d, c, locked, err_pulse, err_cnt, word_cnt);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        data_valid = 1'b0; data_in = 16'h0; clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic lock_seq();
        step(1, 16'h1001, 0);
        step(1, 16'h2003, 0);
        step(1, 16'h4007, 0);
        step(1, 16'h800E, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_cnt !== 16'd0 || word_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: got locked=%0b pulse=%0b err=%0d words=%0d, want 0 0 0 0",
                     locked, err_pulse, err_cnt, word_cnt);
        end
    endtask

    task automatic test_lock();
        step(1, 16'h1001, 0);
        step(1, 16'h2003, 0);
        step(1, 16'h4007, 0);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL early_lock: got locked=%0b, want 0", locked);
        end
        step(1, 16'h800E, 0);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL lock: got locked=%0b err=%0d, want 1 0", locked, err_cnt);
        end
    endtask

    task automatic test_single_error();
        // Prediction runs 001D, 003A, 0074; the first word is corrupted.
        step(1, 16'h001C, 0);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 16'd1) begin
            failures++;
            $display("FAIL err_pulse_hi: got pulse=%0b err=%0d, want 1 1", err_pulse, err_cnt);
        end
        step(1, 16'h003A, 0);
        checks++;
        if (err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse_width: got pulse=%0b, want 0", err_pulse);
        end
        step(1, 16'h0074, 0);
        checks++;
        if (err_cnt !== 16'd1 || locked !== 1'b1 || word_cnt !== 16'd3) begin
            failures++;
            $display("FAIL single_error: got err=%0d locked=%0b words=%0d, want 1 1 3",
                     err_cnt, locked, word_cnt);
        end
        step(0, 16'h1234, 0);
        checks++;
        if (word_cnt !== 16'd3 || err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: got words=%0d pulse=%0b, want 3 0", word_cnt, err_pulse);
        end
    endtask

    task automatic test_unlock();
        step(0, 16'h0000, 1);
        for (int i = 0; i < 3; i++) step(1, 16'hFFFF, 0);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 16'd3) begin
            failures++;
            $display("FAIL pre_unlock: got locked=%0b err=%0d, want 1 3", locked, err_cnt);
        end
        step(1, 16'hFFFF, 0);
        checks++;
        if (locked !== 1'b0 || err_cnt !== 16'd4 || word_cnt !== 16'd4) begin
            failures++;
            $display("FAIL unlock: got locked=%0b err=%0d words=%0d, want 0 4 4",
                     locked, err_cnt, word_cnt);
        end
        lock_seq();
        checks++;
        if (locked !== 1'b1 || err_cnt !== 16'd4) begin
            failures++;
            $display("FAIL relock: got locked=%0b err=%0d, want 1 4", locked, err_cnt);
        end
    endtask

    task automatic test_zero_ignored();
        do_reset();
        step(1, 16'h1001, 0);
        step(1, 16'h0000, 0);
        step(1, 16'h2003, 0);
        step(1, 16'h4007, 0);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL zero_early: got locked=%0b, want 0", locked);
        end
        step(1, 16'h800E, 0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL zero_ignored: got locked=%0b, want 1", locked);
        end
    endtask

    task automatic test_clear_collision();
        step(1, 16'hABCD, 1);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 16'd0 || word_cnt !== 16'd0) begin
            failures++;
            $display("FAIL clr_collision: got pulse=%0b err=%0d words=%0d, want 1 0 0",
                     err_pulse, err_cnt, word_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        lock_seq();
        for (int i = 0; i < 5; i++) step(1, 16'hFFFF, 0);
        checks++;
        if (locked_s !== 1'b1 || err_cnt_s !== 2'd3 || word_cnt_s !== 2'd3) begin
            failures++;
            $display("FAIL saturation: got locked=%0b err=%0d words=%0d, want 1 3 3",
                     locked_s, err_cnt_s, word_cnt_s);
        end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        lock_seq();
        step(1, 16'h0000, 0);
        do_reset();
        checks++;
        if (locked !== 1'b0 || err_cnt !== 16'd0 || word_cnt !== 16'd0 || err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_lock: got locked=%0b err=%0d words=%0d pulse=%0b, want 0 0 0 0",
                     locked, err_cnt, word_cnt, err_pulse);
        end
        // Three words give only two transitions, which is not enough to lock.
        step(1, 16'h2003, 0);
        step(1, 16'h4007, 0);
        step(1, 16'h800E, 0);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL relock_short: got locked=%0b, want 0", locked);
        end
        step(1, 16'h001D, 0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL relock_full: got locked=%0b, want 1", locked);
        end
    endtask

    initial begin
        reset = 1'b1;
        data_valid = 1'b0; data_in = 16'h0; clr_cnt = 1'b0;
        test_reset();
        test_lock();
        test_single_error();
        test_unlock();
        test_zero_ignored();
        test_clear_collision();
        test_saturation();
        test_reset_mid_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
